// File: rtl/shreg_cfg_if.sv
// Loader-facing bundle of the configuration chain: serial/parallel load inputs,
// shadow config word, counter and status. Master = loader, slave = chain.
interface shreg_cfg_if #(
  parameter int DEPTH = 1600,
  parameter int LANES = 1
);
  localparam int NSHIFT = DEPTH / LANES;
  localparam int CNT_W  = $clog2(NSHIFT + 1);

  logic              shreg_enable;
  logic [LANES-1:0]  shreg_in;
  logic [LANES-1:0]  shreg_out;
  logic              capture;
  logic [DEPTH-1:0]  capture_data;
  logic              update;
  logic [DEPTH-1:0]  cfg_out;
  logic [CNT_W-1:0]  shift_cnt;
  logic              full;
  logic              upd_err;

  modport master (
    output shreg_enable, shreg_in, capture, capture_data, update,
    input  shreg_out, cfg_out, shift_cnt, full, upd_err
  );

  modport slave (
    input  shreg_enable, shreg_in, capture, capture_data, update,
    output shreg_out, cfg_out, shift_cnt, full, upd_err
  );
endinterface

// File: rtl/shreg_cfg.sv
// Multi-lane config scan chain with parallel capture, saturating shift counter and a
// shadow register; a word reaches shreg_out after DEPTH/LANES enabled shifts, no stalls.
module shreg_cfg #(
  parameter int DEPTH = 1600,
  parameter int LANES = 1
) (
  input  logic       clk,
  input  logic       rst,
  shreg_cfg_if.slave bus
);
  localparam int NSHIFT = DEPTH / LANES;
  localparam int CNT_W  = $clog2(NSHIFT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NSHIFT);

  logic [DEPTH-1:0] storage;
  logic [DEPTH-1:0] cfg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             upd_err_q;
  logic             full_w;
  logic             do_shift;
  logic             upd_ok;

  assign full_w   = (cnt_q == CNT_MAX);
  assign do_shift = bus.shreg_enable && !bus.capture;
  // Update is judged against the counter as it stood before this edge.
  assign upd_ok   = bus.update && full_w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      storage   <= '0;
      cfg_q     <= '0;
      cnt_q     <= '0;
      upd_err_q <= 1'b0;
    end else begin
      upd_err_q <= bus.update && !full_w;
      if (upd_ok)
        cfg_q <= storage;

      if (bus.capture) begin
        storage <= bus.capture_data;
        cnt_q   <= '0;
      end else if (do_shift) begin
        storage <= {storage[DEPTH-LANES-1:0], bus.shreg_in};
        if (upd_ok)
          cnt_q <= CNT_W'(1);
        else if (!full_w)
          cnt_q <= cnt_q + CNT_W'(1);
      end else if (upd_ok) begin
        cnt_q <= '0;
      end
    end
  end

  assign bus.shreg_out = storage[DEPTH-1 -: LANES];
  assign bus.cfg_out   = cfg_q;
  assign bus.shift_cnt = cnt_q;
  assign bus.full      = full_w;
  assign bus.upd_err   = upd_err_q;
endmodule

// File: tb/tb_shreg_cfg.sv
// Directed bench for shreg_cfg: a default-size chain and a DEPTH=8/LANES=2 chain.
module tb_shreg_cfg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  shreg_cfg_if a_if ();
  shreg_cfg_if #(.DEPTH(8), .LANES(2)) b_if ();

  shreg_cfg u_a (.clk(clk), .rst(rst), .bus(a_if));
  shreg_cfg #(.DEPTH(8), .LANES(2)) u_b (.clk(clk), .rst(rst), .bus(b_if));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic b_shift(input logic [1:0] w);
    b_if.shreg_enable = 1'b1;
    b_if.shreg_in     = w;
    step();
    b_if.shreg_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    nvec++; if (a_if.shift_cnt !== 11'd0) begin nerr++; $display("FAIL reset_a_cnt got %0d want 0", a_if.shift_cnt); end
    nvec++; if (a_if.full !== 1'b0 || a_if.upd_err !== 1'b0) begin nerr++; $display("FAIL reset_a_flags got full=%b err=%b want 0 0", a_if.full, a_if.upd_err); end
    nvec++; if (a_if.cfg_out !== '0 || a_if.shreg_out !== 1'b0) begin nerr++; $display("FAIL reset_a_data got out=%b cfg nonzero=%b want 0", a_if.shreg_out, |a_if.cfg_out); end
    nvec++; if (b_if.cfg_out !== 8'h00 || u_b.storage !== 8'h00) begin nerr++; $display("FAIL reset_b_data got cfg=%h stor=%h want 00 00", b_if.cfg_out, u_b.storage); end
    nvec++; if (b_if.shift_cnt !== 3'd0 || b_if.full !== 1'b0) begin nerr++; $display("FAIL reset_b_cnt got cnt=%0d full=%b want 0 0", b_if.shift_cnt, b_if.full); end
  endtask

  task automatic test_fill_default();
    int early = 0;
    a_if.shreg_enable = 1'b1;
    a_if.shreg_in     = 1'b1;
    for (int i = 1; i <= 1600; i++) begin
      step();
      if (i < 1600 && a_if.shreg_out !== 1'b0) early++;
    end
    nvec++; if (early != 0) begin nerr++; $display("FAIL fill_early got %0d nonzero outputs want 0", early); end
    nvec++; if (a_if.shreg_out !== 1'b1) begin nerr++; $display("FAIL fill_out got %b want 1", a_if.shreg_out); end
    nvec++; if (a_if.shift_cnt !== 11'd1600 || a_if.full !== 1'b1) begin nerr++; $display("FAIL fill_cnt got cnt=%0d full=%b want 1600 1", a_if.shift_cnt, a_if.full); end
    step();
    a_if.shreg_enable = 1'b0;
    nvec++; if (a_if.shift_cnt !== 11'd1600 || a_if.full !== 1'b1) begin nerr++; $display("FAIL fill_sat got cnt=%0d full=%b want 1600 1", a_if.shift_cnt, a_if.full); end
  endtask

  task automatic test_upd_reject_then_accept();
    b_shift(2'b01);
    b_shift(2'b10);
    b_shift(2'b11);
    b_if.update = 1'b1;
    step();
    b_if.update = 1'b0;
    nvec++; if (b_if.upd_err !== 1'b1) begin nerr++; $display("FAIL rej_err got %b want 1", b_if.upd_err); end
    nvec++; if (b_if.cfg_out !== 8'h00 || b_if.shift_cnt !== 3'd3) begin nerr++; $display("FAIL rej_state got cfg=%h cnt=%0d want 00 3", b_if.cfg_out, b_if.shift_cnt); end
    step();
    nvec++; if (b_if.upd_err !== 1'b0 || b_if.shift_cnt !== 3'd3) begin nerr++; $display("FAIL rej_pulse got err=%b cnt=%0d want 0 3", b_if.upd_err, b_if.shift_cnt); end
    b_shift(2'b00);
    nvec++; if (u_b.storage !== 8'b01101100 || b_if.full !== 1'b1) begin nerr++; $display("FAIL acc_load got stor=%b full=%b want 01101100 1", u_b.storage, b_if.full); end
    b_if.update = 1'b1;
    step();
    b_if.update = 1'b0;
    nvec++; if (b_if.cfg_out !== 8'b01101100) begin nerr++; $display("FAIL acc_cfg got %b want 01101100", b_if.cfg_out); end
    nvec++; if (b_if.shift_cnt !== 3'd0 || b_if.full !== 1'b0 || b_if.upd_err !== 1'b0) begin nerr++; $display("FAIL acc_cnt got cnt=%0d full=%b err=%b want 0 0 0", b_if.shift_cnt, b_if.full, b_if.upd_err); end
  endtask

  task automatic test_capture();
    b_shift(2'b11);
    b_if.capture      = 1'b1;
    b_if.capture_data = 8'hA5;
    b_if.shreg_enable = 1'b1;
    b_if.shreg_in     = 2'b11;
    step();
    b_if.capture      = 1'b0;
    b_if.shreg_enable = 1'b0;
    nvec++; if (u_b.storage !== 8'hA5 || b_if.shreg_out !== 2'b10) begin nerr++; $display("FAIL cap_data got stor=%h out=%b want a5 10", u_b.storage, b_if.shreg_out); end
    nvec++; if (b_if.shift_cnt !== 3'd0 || b_if.cfg_out !== 8'h6C) begin nerr++; $display("FAIL cap_cnt got cnt=%0d cfg=%h want 0 6c", b_if.shift_cnt, b_if.cfg_out); end
  endtask

  task automatic test_update_shift();
    b_shift(2'b00);
    b_shift(2'b11);
    b_shift(2'b11);
    b_shift(2'b00);
    b_if.update       = 1'b1;
    b_if.shreg_enable = 1'b1;
    b_if.shreg_in     = 2'b11;
    step();
    b_if.update       = 1'b0;
    b_if.shreg_enable = 1'b0;
    nvec++; if (b_if.cfg_out !== 8'h3C || u_b.storage !== 8'hF3) begin nerr++; $display("FAIL updsh_data got cfg=%h stor=%h want 3c f3", b_if.cfg_out, u_b.storage); end
    nvec++; if (b_if.shift_cnt !== 3'd1 || b_if.full !== 1'b0) begin nerr++; $display("FAIL updsh_cnt got cnt=%0d full=%b want 1 0", b_if.shift_cnt, b_if.full); end
  endtask

  task automatic test_update_capture();
    b_shift(2'b00);
    b_shift(2'b00);
    b_shift(2'b00);
    nvec++; if (u_b.storage !== 8'hC0 || b_if.full !== 1'b1) begin nerr++; $display("FAIL updcap_pre got stor=%h full=%b want c0 1", u_b.storage, b_if.full); end
    b_if.update       = 1'b1;
    b_if.capture      = 1'b1;
    b_if.capture_data = 8'h5A;
    step();
    b_if.update  = 1'b0;
    b_if.capture = 1'b0;
    nvec++; if (b_if.cfg_out !== 8'hC0 || u_b.storage !== 8'h5A) begin nerr++; $display("FAIL updcap_data got cfg=%h stor=%h want c0 5a", b_if.cfg_out, u_b.storage); end
    nvec++; if (b_if.shift_cnt !== 3'd0 || b_if.upd_err !== 1'b0) begin nerr++; $display("FAIL updcap_cnt got cnt=%0d err=%b want 0 0", b_if.shift_cnt, b_if.upd_err); end
  endtask

  task automatic test_reset_mid();
    b_shift(2'b00);
    b_shift(2'b11);
    b_shift(2'b11);
    b_shift(2'b00);
    b_if.update = 1'b1;
    step();
    b_if.update = 1'b0;
    nvec++; if (b_if.cfg_out !== 8'h3C) begin nerr++; $display("FAIL rstmid_pre got cfg=%h want 3c", b_if.cfg_out); end
    b_shift(2'b10);
    // Update with a non-full counter would flag upd_err if reset failed to dominate.
    rst               = 1'b0;
    b_if.update       = 1'b1;
    b_if.shreg_enable = 1'b1;
    b_if.shreg_in     = 2'b11;
    step();
    rst               = 1'b1;
    b_if.update       = 1'b0;
    b_if.shreg_enable = 1'b0;
    nvec++; if (b_if.cfg_out !== 8'h00 || u_b.storage !== 8'h00) begin nerr++; $display("FAIL rstmid_data got cfg=%h stor=%h want 00 00", b_if.cfg_out, u_b.storage); end
    nvec++; if (b_if.shift_cnt !== 3'd0 || b_if.upd_err !== 1'b0 || b_if.full !== 1'b0) begin nerr++; $display("FAIL rstmid_cnt got cnt=%0d err=%b full=%b want 0 0 0", b_if.shift_cnt, b_if.upd_err, b_if.full); end
    nvec++; if (a_if.shift_cnt !== 11'd0 || a_if.shreg_out !== 1'b0) begin nerr++; $display("FAIL rstmid_a got cnt=%0d out=%b want 0 0", a_if.shift_cnt, a_if.shreg_out); end
  endtask

  initial begin
    a_if.shreg_enable = 1'b0;
    a_if.shreg_in     = 1'b0;
    a_if.capture      = 1'b0;
    a_if.capture_data = '0;
    a_if.update       = 1'b0;
    b_if.shreg_enable = 1'b0;
    b_if.shreg_in     = 2'b00;
    b_if.capture      = 1'b0;
    b_if.capture_data = 8'h00;
    b_if.update       = 1'b0;

    test_reset();
    test_fill_default();
    test_upd_reject_then_accept();
    test_capture();
    test_update_shift();
    test_update_capture();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/shreg_cfg.md
Name: shreg_cfg

Overview:
- Parametrised successor of the single-bit serial shift register.
- Multi-lane serial chain of configurable depth, plus:
  - parallel capture port
  - shift counter with full flag
  - shadow (update) register, so downstream logic sees a stable configuration word while a new one is shifted in
- Used as the configuration/scan chain between the off-chip serial loader and MARTIn datapath config bits.

Parameters:
- DEPTH, 1600, total chain length in bits; must be a multiple of LANES and >= 2*LANES.
- LANES, 1, bits shifted per enabled cycle (serial lane count).
- NSHIFT (derived localparam, not overridable), DEPTH/LANES, shifts needed to fill the chain.
- CNT_W (derived localparam, not overridable), $clog2(NSHIFT+1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- shreg_enable  in  1  shift one LANES-wide word this cycle.
- shreg_in  in  LANES  serial input word.
- shreg_out  out  LANES  serial output word = storage[DEPTH-1 -: LANES].
- capture  in  1  parallel-load capture_data into storage.
- capture_data  in  DEPTH  parallel capture value.
- update  in  1  request copy of storage into shadow.
- cfg_out  out  DEPTH  shadow register contents.
- shift_cnt  out  CNT_W  shifts since last capture/accepted update, saturating at NSHIFT.
- full  out  1  high when shift_cnt == NSHIFT.
- upd_err  out  1  one-cycle pulse: update rejected.

Behaviour:
- Reset, sampled at posedge clk with rst==0, clears:
  - storage, cfg_out and shift_cnt to 0
  - full = 0, upd_err = 0, shreg_out = 0
  - Reset overrides all other inputs in that cycle.
- Shift (shreg_enable==1, capture==0):
  - storage <= {storage[DEPTH-LANES-1:0], shreg_in}.
  - shreg_in[0] enters bit 0.
  - The word entering on cycle k appears on shreg_out after NSHIFT enabled shifts.
  - shift_cnt increments, saturating at NSHIFT.
- shreg_enable==0 and capture==0: storage holds.
- Capture (capture==1):
  - storage <= capture_data.
  - shift_cnt <= 0.
  - Wins over shreg_enable in the same cycle; the shift is dropped and not counted.
- Update (update==1):
  - Accepted only if full==1 in that cycle (evaluated before this edge).
  - Accepted: cfg_out <= current storage (pre-shift value if shreg_enable is also high).
  - shift_cnt <= 1 if a shift also occurs that cycle, else 0.
  - Rejected (full==0): cfg_out unchanged; upd_err=1 for exactly the next cycle; counter behaves as if update absent.
- update together with capture:
  - Update is evaluated first, against old storage/full.
  - Then capture applies: storage <= capture_data, shift_cnt <= 0.
- cfg_out changes only on reset or an accepted update. It is never disturbed by shifting or capture.
- full is combinational from shift_cnt (registered state). No added latency.
- shreg_out is combinational from storage. Latency from input word to output = NSHIFT enabled cycles.
- Counter saturation: further shifts at NSHIFT keep full=1. Data continues to shift and the oldest words fall out on shreg_out.
- Reset mid-load: partial chain discarded, cfg_out cleared to 0. Downstream must treat all-zero as the safe config.

Test Plan:
- Default params, rst low 2 cycles then high, shift 1600 ones -> shreg_out=0 for shifts 1..1599, =1 after shift 1600; shift_cnt=1600, full=1.
- DEPTH=8, LANES=2: shift words 2'b01,2'b10,2'b11,2'b00 then update -> cfg_out=8'b01101100; shift_cnt=0; full=0.
- DEPTH=8, LANES=2: 3 shifts then update -> upd_err high exactly one cycle; cfg_out unchanged (0); shift_cnt stays 3.
- DEPTH=8, LANES=2: capture=1 with capture_data=8'hA5 and shreg_enable=1 in the same cycle -> storage=8'hA5; shreg_out=2'b10; shift_cnt=0.
- DEPTH=8, LANES=2, chain full with 8'h3C: update + shreg_enable with shreg_in=2'b11 in the same cycle -> cfg_out=8'h3C; storage=8'hF3; shift_cnt=1.
- After loading cfg_out=8'h3C, assert rst for 1 cycle mid-shift -> cfg_out=0, storage=0, shift_cnt=0, upd_err=0 next cycle.
